// File: rtl/alu_m_pkg.sv
// alu_m_pkg: shared encodings and the preset operand table for the alu_m LED-lab ALU.
// Optional carry flag is enabled by defining ALU_M_CF_EN (see alu_m_core / alu_m).
package alu_m_pkg;

    // Operation select encodings (ALU_OP)
    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_NOR = 3'b011,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101,
        OP_SLT = 3'b110,
        OP_SLL = 3'b111
    } alu_op_e;

    // LED display select encodings (F_LED_SW); any value with bit 2 set shows the flags
    localparam logic [2:0] LED_SEL_B0    = 3'b000;
    localparam logic [2:0] LED_SEL_B1    = 3'b001;
    localparam logic [2:0] LED_SEL_B2    = 3'b010;
    localparam logic [2:0] LED_SEL_B3    = 3'b011;
    localparam logic [2:0] LED_SEL_FLAGS = 3'b100;
    localparam int unsigned LedFlagBit   = 2;

    // Preset operand pairs selected by AB_SW
    localparam logic [31:0] OPA_0 = 32'h0000_0000;
    localparam logic [31:0] OPB_0 = 32'h0000_0000;
    localparam logic [31:0] OPA_1 = 32'h0000_0003;
    localparam logic [31:0] OPB_1 = 32'h0000_0607;
    localparam logic [31:0] OPA_2 = 32'h8000_0000;
    localparam logic [31:0] OPB_2 = 32'h8000_0000;
    localparam logic [31:0] OPA_3 = 32'h7FFF_FFFF;
    localparam logic [31:0] OPB_3 = 32'h7FFF_FFFF;
    localparam logic [31:0] OPA_4 = 32'hFFFF_FFFF;
    localparam logic [31:0] OPB_4 = 32'hFFFF_FFFF;
    localparam logic [31:0] OPA_5 = 32'h8000_0000;
    localparam logic [31:0] OPB_5 = 32'hFFFF_FFFF;
    localparam logic [31:0] OPA_6 = 32'hFFFF_FFFF;
    localparam logic [31:0] OPB_6 = 32'h8000_0000;
    localparam logic [31:0] OPA_7 = 32'h1234_5678;
    localparam logic [31:0] OPB_7 = 32'h3333_2222;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } operand_pair_t;

    // Operand ROM lookup
    function automatic operand_pair_t operand_pair(input logic [2:0] sel);
        operand_pair_t p;
        unique case (sel)
            3'd0: p = '{a: OPA_0, b: OPB_0};
            3'd1: p = '{a: OPA_1, b: OPB_1};
            3'd2: p = '{a: OPA_2, b: OPB_2};
            3'd3: p = '{a: OPA_3, b: OPB_3};
            3'd4: p = '{a: OPA_4, b: OPB_4};
            3'd5: p = '{a: OPA_5, b: OPB_5};
            3'd6: p = '{a: OPA_6, b: OPB_6};
            3'd7: p = '{a: OPA_7, b: OPB_7};
            default: p = '{a: OPA_0, b: OPB_0};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/alu_m_core.sv
// alu_m_core: purely combinational ALU datapath producing result and flags.
// Defining ALU_M_CF_EN adds the cf_o carry/borrow output.
module alu_m_core
    import alu_m_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_e          op_i,
    output logic [WIDTH-1:0] f_o,
    output logic             zf_o,
`ifdef ALU_M_CF_EN
    output logic             cf_o,
`endif
    output logic             of_o
);

    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic             add_ovf;
    logic             sub_ovf;
`ifdef ALU_M_CF_EN
    logic             add_carry;
    logic             sub_borrow;
`endif

    // Shared adder/subtractor and their overflow conditions
    always_comb begin
`ifdef ALU_M_CF_EN
        {add_carry, add_res} = {1'b0, a_i} + {1'b0, b_i};
        sub_borrow           = (a_i < b_i);
`else
        add_res = a_i + b_i;
`endif
        sub_res = a_i - b_i;
        // Same-sign operands whose sum flips sign
        add_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (add_res[WIDTH-1] != a_i[WIDTH-1]);
        // Opposite-sign operands whose difference takes B's sign
        sub_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sub_res[WIDTH-1] != a_i[WIDTH-1]);
    end

    // Operation select and flag generation
    always_comb begin
        f_o  = '0;
        of_o = 1'b0;
`ifdef ALU_M_CF_EN
        cf_o = 1'b0;
`endif
        unique case (op_i)
            OP_AND: f_o = a_i & b_i;
            OP_OR:  f_o = a_i | b_i;
            OP_XOR: f_o = a_i ^ b_i;
            OP_NOR: f_o = ~(a_i | b_i);
            OP_ADD: begin
                f_o  = add_res;
                of_o = add_ovf;
`ifdef ALU_M_CF_EN
                cf_o = add_carry;
`endif
            end
            OP_SUB: begin
                f_o  = sub_res;
                of_o = sub_ovf;
`ifdef ALU_M_CF_EN
                cf_o = sub_borrow;
`endif
            end
            OP_SLT: f_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLL: f_o = b_i << a_i[4:0];
            default: f_o = '0;
        endcase
        zf_o = (f_o == '0);
    end

endmodule

// File: rtl/alu_m.sv
// alu_m: LED-lab ALU top. Operand ROM, registered result/flags and the LED display mux.
// Defining ALU_M_CF_EN adds a registered carry flag shown on LED[5] in flag mode.
module alu_m
    import alu_m_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] ALU_OP,
    input  logic [2:0] AB_SW,
    input  logic [2:0] F_LED_SW,
    output logic [7:0] LED
);

    operand_pair_t    operands;
    logic [WIDTH-1:0] f_d;
    logic [WIDTH-1:0] f_q;
    logic             zf_d;
    logic             zf_q;
    logic             of_d;
    logic             of_q;
    logic             cf_led;
`ifdef ALU_M_CF_EN
    logic             cf_d;
    logic             cf_q;
`endif

    // Operand ROM lookup from the switch setting
    always_comb begin
        operands = operand_pair(AB_SW);
    end

    alu_m_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i  (operands.a),
        .b_i  (operands.b),
        .op_i (alu_op_e'(ALU_OP)),
        .f_o  (f_d),
        .zf_o (zf_d),
`ifdef ALU_M_CF_EN
        .cf_o (cf_d),
`endif
        .of_o (of_d)
    );

    // Result and flag registers, synchronous reset has priority over new inputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            f_q  <= '0;
            zf_q <= 1'b0;
            of_q <= 1'b0;
`ifdef ALU_M_CF_EN
            cf_q <= 1'b0;
`endif
        end else begin
            f_q  <= f_d;
            zf_q <= zf_d;
            of_q <= of_d;
`ifdef ALU_M_CF_EN
            cf_q <= cf_d;
`endif
        end
    end

    // LED view of the registers; switch changes show up without a clock
    always_comb begin
`ifdef ALU_M_CF_EN
        cf_led = cf_q;
`else
        cf_led = 1'b0;
`endif
        LED = 8'h00;
        if (F_LED_SW[LedFlagBit]) begin
            LED = {zf_q, of_q, cf_led, 5'b0};
        end else begin
            unique case (F_LED_SW)
                LED_SEL_B0: LED = f_q[7:0];
                LED_SEL_B1: LED = f_q[15:8];
                LED_SEL_B2: LED = f_q[23:16];
                LED_SEL_B3: LED = f_q[31:24];
                default:    LED = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_m.sv
// tb_alu_m: directed and randomized checks of alu_m against an arithmetic reference model.
// Build with ALU_M_CF_EN defined to also check the carry flag.
module tb_alu_m;

`ifdef ALU_M_CF_EN
    localparam bit CfEn = 1'b1;
`else
    localparam bit CfEn = 1'b0;
`endif
    localparam longint SMax = 64'sd2147483647;
    localparam longint SMin = -64'sd2147483648;
    localparam longint Two32 = 64'sd4294967296;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] alu_op;
    logic [2:0] ab_sw;
    logic [2:0] led_sw;
    logic [7:0] led;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] a_tab [8] = '{32'h00000000, 32'h00000003, 32'h80000000, 32'h7FFFFFFF,
                               32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h12345678};
    logic [31:0] b_tab [8] = '{32'h00000000, 32'h00000607, 32'h80000000, 32'h7FFFFFFF,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h33332222};

    // Model of the registered state
    logic [31:0] exp_f  = '0;
    bit          exp_zf = 1'b0;
    bit          exp_of = 1'b0;
    bit          exp_cf = 1'b0;

    alu_m #(
        .WIDTH (32)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .ALU_OP   (alu_op),
        .AB_SW    (ab_sw),
        .F_LED_SW (led_sw),
        .LED      (led)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic longint to_s(input logic [31:0] v);
        longint u;
        u = longint'(v);
        return v[31] ? u - Two32 : u;
    endfunction

    // Reference ALU computed with wide integer arithmetic
    task automatic ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] f, output bit ovf, output bit cy);
        longint sa, sb, ua, ub, r, s;
        sa = to_s(a);
        sb = to_s(b);
        ua = longint'(a);
        ub = longint'(b);
        ovf = 1'b0;
        cy  = 1'b0;
        f   = '0;
        case (op)
            3'd0: f = a & b;
            3'd1: f = a | b;
            3'd2: f = a ^ b;
            3'd3: f = ~(a | b);
            3'd4: begin
                r   = ua + ub;
                f   = r[31:0];
                cy  = (r >= Two32);
                s   = sa + sb;
                ovf = (s > SMax) || (s < SMin);
            end
            3'd5: begin
                r   = ua - ub;
                f   = r[31:0];
                cy  = (ua < ub);
                s   = sa - sb;
                ovf = (s > SMax) || (s < SMin);
            end
            3'd6: f = (sa < sb) ? 32'd1 : 32'd0;
            default: f = b << a[4:0];
        endcase
    endtask

    function automatic logic [7:0] exp_led(input logic [2:0] sel);
        if (sel[2]) return {exp_zf, exp_of, CfEn & exp_cf, 5'b0};
        return exp_f[8*sel[1:0] +: 8];
    endfunction

    // One rising edge; the model captures the same inputs the DUT sees
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            exp_f  = '0;
            exp_zf = 1'b0;
            exp_of = 1'b0;
            exp_cf = 1'b0;
        end else begin
            ref_alu(alu_op, a_tab[ab_sw], b_tab[ab_sw], exp_f, exp_of, exp_cf);
            exp_zf = (exp_f == '0);
        end
        #1;
    endtask

    task automatic led_is(input string tag, input logic [2:0] sel, input logic [7:0] exp);
        led_sw = sel;
        #1;
        check(tag, {24'b0, led}, {24'b0, exp});
    endtask

    task automatic check_leds(input string tag);
        for (int s = 0; s < 8; s++) begin
            led_sw = s[2:0];
            #1;
            check($sformatf("%s_led%0d", tag, s), {24'b0, led}, {24'b0, exp_led(s[2:0])});
        end
    endtask

    initial begin
        rst    = 1'b1;
        alu_op = 3'($urandom);
        ab_sw  = 3'($urandom);
        led_sw = 3'd0;
        tick();
        for (int s = 0; s < 5; s++) led_is($sformatf("rst_led%0d", s), s[2:0], 8'h00);
        check_leds("rst");

        rst = 1'b0;
        alu_op = 3'b001; ab_sw = 3'b111;
        tick();
        led_is("or_b0", 3'b000, 8'h7A);
        led_is("or_b1", 3'b001, 8'h76);
        led_is("or_b2", 3'b010, 8'h37);
        led_is("or_b3", 3'b011, 8'h33);
        led_is("or_flags", 3'b100, 8'h00);
        check_leds("or");

        alu_op = 3'b100; ab_sw = 3'b011;
        tick();
        led_is("add_ovf_b0", 3'b000, 8'hFE);
        led_is("add_ovf_flags", 3'b100, 8'h40);
        ab_sw = 3'b100;
        tick();
        led_is("add_cy_b0", 3'b000, 8'hFE);
`ifdef ALU_M_CF_EN
        led_is("add_cy_flags", 3'b100, 8'h20);
`else
        led_is("add_cy_flags", 3'b100, 8'h00);
`endif

        alu_op = 3'b101; ab_sw = 3'b000;
        tick();
        led_is("sub0_flags", 3'b100, 8'h80);
        ab_sw = 3'b010;
        tick();
        led_is("sub2_b3", 3'b011, 8'h00);
        led_is("sub2_flags", 3'b100, 8'h80);

        alu_op = 3'b110; ab_sw = 3'b101;
        tick();
        led_is("slt5_b0", 3'b000, 8'h01);
        ab_sw = 3'b110;
        tick();
        led_is("slt6_b0", 3'b000, 8'h00);
        led_is("slt6_flags", 3'b100, 8'h80);

        alu_op = 3'b111; ab_sw = 3'b001;
        tick();
        led_is("sll_b0", 3'b000, 8'h38);
        led_is("sll_b1", 3'b001, 8'h30);

        alu_op = 3'b010; ab_sw = 3'b111;
        led_is("xor_hold_b3", 3'b011, 8'h00);
        tick();
        led_is("xor_b3", 3'b011, 8'h21);
        alu_op = 3'b011; ab_sw = 3'b100;
        tick();
        led_is("nor_flags", 3'b100, 8'h80);

        // Reset mid-sequence while inputs would otherwise produce a nonzero result
        rst = 1'b1; alu_op = 3'b100; ab_sw = 3'b011;
        tick();
        led_is("rst2_b0", 3'b000, 8'h00);
        led_is("rst2_flags", 3'b100, 8'h00);
        rst = 1'b0; alu_op = 3'b001; ab_sw = 3'b111;
        tick();
        led_is("rel_b0", 3'b000, 8'h7A);

        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 15) == 0);
            alu_op = 3'($urandom);
            ab_sw  = 3'($urandom);
            tick();
            if (i % 16 == 0) begin
                check_leds($sformatf("rnd%0d", i));
            end else begin
                led_sw = 3'($urandom);
                #1;
                check($sformatf("rnd%0d_sel%0d", i, led_sw), {24'b0, led},
                      {24'b0, exp_led(led_sw)});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_m.md
Name: alu_m

Overview:
- 32-bit teaching ALU for the board-level LED lab.
- Three switches select one of eight preset operand pairs (A, B); three switches select the operation; three switches select which result byte or flag set drives the 8 LEDs.
- Result and flags are registered once per clock; the LED output is a combinational view of those registers.
- Top-level leaf block, no handshake.

Parameters:
- WIDTH, 32, ALU datapath width. Only 32 is supported; the operand table and LED byte map assume it.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  synchronous, active-high reset
- ALU_OP  input  3  operation select
- AB_SW  input  3  operand-pair select
- F_LED_SW  input  3  LED display select
- LED  output  8  displayed result byte or flags

Behaviour:
- Clocking and reset:
  - One clock (CLK). Reset RST is synchronous and active-high.
  - On a rising CLK edge with RST=1: F_reg=0, ZF_reg=0, OF_reg=0. LED therefore reads 0x00 for every F_LED_SW value.
- Operand table, selected by AB_SW (combinational):
  - 000: A=00000000, B=00000000
  - 001: A=00000003, B=00000607
  - 010: A=80000000, B=80000000
  - 011: A=7FFFFFFF, B=7FFFFFFF
  - 100: A=FFFFFFFF, B=FFFFFFFF
  - 101: A=80000000, B=FFFFFFFF
  - 110: A=FFFFFFFF, B=80000000
  - 111: A=12345678, B=33332222
- Operations, selected by ALU_OP:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NOR
  - 100 ADD, modulo 2^32
  - 101 SUB, A-B modulo 2^32
  - 110 SLT, signed: F=1 if A<B, else 0
  - 111 SLL: F=B<<A[4:0], zero fill
- Flags:
  - ZF = (F==0), for every op.
  - OF = signed overflow for ADD/SUB; OF=0 for all other ops.
  - ADD overflow: A and B have the same sign and F's sign differs from it.
  - SUB overflow: A and B have different signs and F's sign differs from A's.
- Timing:
  - Each rising edge with RST=0 captures F, ZF and OF from the current ALU_OP/AB_SW. Latency is 1 cycle; new inputs are sampled every cycle.
- LED mux (combinational from the registers; a change on F_LED_SW is visible with no clock):
  - 000: F[7:0]
  - 001: F[15:8]
  - 010: F[23:16]
  - 011: F[31:24]
  - 1xx: {ZF, OF, 6'b0}
- Boundary conditions:
  - RST together with input changes: reset wins.
  - Releasing reset: the first non-reset edge loads a normal result.
  - No undefined encodings; all 8×8 input combinations are valid.

Optional Feature:
- Macro ALU_M_CF_EN.
- Defined: a third flag register CF is added, reset to 0.
  - ADD: CF = carry-out of bit 31.
  - SUB: CF = borrow, i.e. A<B unsigned.
  - Other ops: CF = 0.
  - LED for F_LED_SW=1xx is {ZF, OF, CF, 5'b0}.
- Undefined: no CF register; LED[5]=0 in flag mode.

Decomposition:
- Package alu_m_pkg holds:
  - ALU_OP encodings (OP_AND..OP_SLL)
  - the eight A/B operand constants
  - the F_LED_SW select encodings
- One natural sub-module, alu_m_core: purely combinational; inputs A, B, op; outputs F, ZF, OF (and CF under ALU_M_CF_EN).
- alu_m holds the operand ROM, the flag/result registers and the LED mux.

Test Plan:
- Reset: RST=1 for one edge with arbitrary inputs -> LED=00 for F_LED_SW 000..100. Assert RST again mid-sequence -> LED returns to 00 after that edge.
- OR: ALU_OP=001, AB_SW=111, one edge -> F=3337767A. Sweep F_LED_SW=000/001/010/011 with no clock -> LED=7A/76/37/33. F_LED_SW=100 -> LED=00.
- ADD overflow: ALU_OP=100, AB_SW=011 -> F=FFFFFFFE, LED(000)=FE, LED(100)=40. With ALU_M_CF_EN, AB_SW=100 -> F=FFFFFFFE, LED(100)=20.
- SUB zero: ALU_OP=101, AB_SW=000 -> F=0, LED(100)=80. AB_SW=010 -> F=0, LED(100)=80.
- SLT/SLL:
  - ALU_OP=110, AB_SW=101 -> F=1, LED(000)=01.
  - ALU_OP=110, AB_SW=110 -> F=0, LED(100)=80.
  - ALU_OP=111, AB_SW=001 -> F=00003038, LED(000)=38, LED(001)=30.
- XOR/NOR plus latency: ALU_OP=010, AB_SW=111 -> LED(011)=21 only after the next edge (the previous value holds before it). Then ALU_OP=011, AB_SW=100 -> F=0, LED(100)=80.
